// File: rtl/present_pbox_pipe_if.sv
// ---------------------------------------------------------------------------
// present_pbox_pipe_if
//   Valid/ready stream carrying one cipher-state block and its direction flag.
//   One instance describes one side of the pipe. The producer uses the master
//   modport and the consumer uses the slave modport.
//
//   Signals
//     valid  producer -> consumer  data/inv carry a block
//     ready  consumer -> producer  block is taken when valid && ready
//     data   producer -> consumer  WIDTH-bit cipher state
//     inv    producer -> consumer  0 = forward pLayer, 1 = inverse pLayer
// ---------------------------------------------------------------------------
interface present_pbox_pipe_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             inv;

    modport master (output valid, output data, output inv, input  ready);
    modport slave  (input  valid, input  data, input  inv, output ready);
endinterface

// File: rtl/present_pbox_pipe.sv
// ---------------------------------------------------------------------------
// present_pbox_pipe
//   Pipelined PRESENT-style bit-permutation layer. It supports the forward and
//   inverse directions, and the direction is chosen for each block. It sits
//   between the S-box layer and the round-key XOR. It is an elastic pipeline
//   of STAGES registers, so a stalled sink never causes data loss.
//   WIDTH=64 in forward mode is the standard PRESENT pLayer.
//
//   Parameters
//     WIDTH   state width in bits. Must be a multiple of 4 and at least 8.
//     STAGES  number of register stages, 1..4.
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset. Clears every stage.
//     in_if   slave stream. Pre-permutation state plus direction flag.
//     out_if  master stream. Permuted state plus the echoed direction flag.
// ---------------------------------------------------------------------------
module present_pbox_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    present_pbox_pipe_if.slave   in_if,
    present_pbox_pipe_if.master  out_if
);

    localparam int QUARTER = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("present_pbox_pipe: WIDTH must be a multiple of 4 and >= 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("present_pbox_pipe: STAGES must be in 1..4");
    end

    // Both permutations are plain wiring. The forward map multiplies the bit
    // index by WIDTH/4 and the inverse map multiplies it by 4, both modulo
    // WIDTH-1. Because 4*(WIDTH/4) = WIDTH, which is 1 mod (WIDTH-1), the two
    // maps undo each other. The top bit maps to itself in both directions.
    logic [WIDTH-1:0] fwd_p;
    logic [WIDTH-1:0] inv_p;
    logic [WIDTH-1:0] perm;

    for (genvar i = 0; i < WIDTH; i++) begin : g_perm
        if (i == WIDTH - 1) begin : g_top
            assign fwd_p[i] = in_if.data[i];
            assign inv_p[i] = in_if.data[i];
        end else begin : g_rest
            assign fwd_p[(i * QUARTER) % (WIDTH - 1)] = in_if.data[i];
            assign inv_p[(i * 4) % (WIDTH - 1)]       = in_if.data[i];
        end
    end

    assign perm = in_if.inv ? inv_p : fwd_p;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] inv_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] load;

    // A stage may load when it or any stage after it is empty, or when the
    // sink is taking a block. This is the ready chain written in flat form.
    // Written this way, no load bit depends on another load bit.
    for (genvar k = 0; k < STAGES; k++) begin : g_load
        assign load[k] = out_if.ready | ~(&v[STAGES-1:k]);
    end

    // Next contents of each stage. Stage 0 takes the permuted input and every
    // later stage takes the contents of the stage in front of it.
    logic [STAGES-1:0] nxt_v;
    logic [STAGES-1:0] nxt_inv;
    logic [WIDTH-1:0]  nxt_data [STAGES];

    always_comb begin
        nxt_v[0]    = in_if.valid;
        nxt_inv[0]  = in_if.inv;
        nxt_data[0] = perm;
        for (int k = 1; k < STAGES; k++) begin
            nxt_v[k]    = v[k-1];
            nxt_inv[k]  = inv_q[k-1];
            nxt_data[k] = data_q[k-1];
        end
    end

    // Valid bits follow the load condition on every cycle. The payload is
    // written only when a real block arrives, so empty slots keep their old
    // contents and do not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            inv_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k] <= nxt_v[k];
                    if (nxt_v[k]) begin
                        inv_q[k]  <= nxt_inv[k];
                        data_q[k] <= nxt_data[k];
                    end
                end
            end
        end
    end

    assign in_if.ready  = load[0];
    assign out_if.valid = v[STAGES-1];
    assign out_if.inv   = inv_q[STAGES-1];
    assign out_if.data  = data_q[STAGES-1];

endmodule

// File: tb/tb_present_pbox_pipe.sv
// ---------------------------------------------------------------------------
// tb_present_pbox_pipe
//   Exercises three instances of present_pbox_pipe:
//     dut_a  WIDTH=64, STAGES=2
//     dut_b  WIDTH=16, STAGES=1
//     dut_c  WIDTH=16, STAGES=4
//   Expected results come from a reference model of the permutation. The
//   model treats the permutation as a transpose of a 4 x (WIDTH/4) bit
//   matrix. An in-order scoreboard checks every block that leaves dut_a.
// ---------------------------------------------------------------------------
module tb_present_pbox_pipe;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    present_pbox_pipe_if #(.WIDTH(64)) a_in ();
    present_pbox_pipe_if #(.WIDTH(64)) a_out ();
    present_pbox_pipe_if #(.WIDTH(16)) b_in ();
    present_pbox_pipe_if #(.WIDTH(16)) b_out ();
    present_pbox_pipe_if #(.WIDTH(16)) c_in ();
    present_pbox_pipe_if #(.WIDTH(16)) c_out ();

    present_pbox_pipe #(.WIDTH(64), .STAGES(2)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_if  (a_in),
        .out_if (a_out)
    );

    present_pbox_pipe #(.WIDTH(16), .STAGES(1)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_if  (b_in),
        .out_if (b_out)
    );

    present_pbox_pipe #(.WIDTH(16), .STAGES(4)) dut_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_if  (c_in),
        .out_if (c_out)
    );

    typedef struct {
        logic [63:0] data;
        logic        inv;
        int          cyc;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    exp_t        sbQ[$];
    logic [63:0] capQ[$];
    int          lastLat = -1;
    logic [63:0] lastOut = '0;
    logic        lastOutInv = 1'b0;
    logic        stallPrev = 1'b0;
    logic [65:0] held = '0;
    int          emitCount = 0;
    int          firstEmitCyc = 0;
    int          lastEmitCyc = 0;
    logic [63:0] orig [1000];
    logic [63:0] fwdRes [1000];

    // The model views the state as a 4 x (w/4) matrix of bits. Bit i sits at
    // row i%4, column i/4. The forward pLayer transposes that matrix. The
    // inverse pLayer transposes it back.
    function automatic logic [63:0] refPerm(input logic [63:0] d, input int w, input bit inv);
        logic [63:0] o;
        int q;
        o = '0;
        q = w / 4;
        for (int i = 0; i < w; i++) begin
            if (!inv) o[(i % 4) * q + i / 4] = d[i];
            else      o[(i % q) * 4 + i / q] = d[i];
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one clock cycle on dut_a. The inputs are driven just after the
    // rising edge and the handshakes are sampled on the falling edge. Any
    // block that leaves the pipe is checked against the scoreboard.
    task automatic applyStimulus(input logic iv, input logic [63:0] d, input logic ii,
                                 input logic ordy, output logic acc);
        exp_t e;
        a_in.valid  = iv;
        a_in.data   = d;
        a_in.inv    = ii;
        a_out.ready = ordy;
        @(negedge clk);
        acc = iv && a_in.ready;
        if (stallPrev)
            checkOutput("stall_hold", {a_out.valid, a_out.inv, a_out.data}, held);
        if (acc)
            sbQ.push_back('{data: refPerm(d, 64, ii), inv: ii, cyc: cyc});
        if (a_out.valid && ordy) begin
            if (sbQ.size() == 0) begin
                checkOutput("no_stale_out", 66'(a_out.valid), 66'(0));
            end else begin
                e = sbQ.pop_front();
                checkOutput("out_data", 66'(a_out.data), 66'(e.data));
                checkOutput("out_inv", 66'(a_out.inv), 66'(e.inv));
                lastLat = cyc - e.cyc;
            end
            lastOut    = a_out.data;
            lastOutInv = a_out.inv;
            capQ.push_back(a_out.data);
            if (emitCount == 0) firstEmitCyc = cyc;
            lastEmitCyc = cyc;
            emitCount++;
        end
        stallPrev = a_out.valid && !ordy;
        held      = {a_out.valid, a_out.inv, a_out.data};
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic sendA(input logic [63:0] d, input logic ii, input logic ordy);
        logic acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            applyStimulus(1'b1, d, ii, ordy, acc);
            n++;
        end
        checkOutput("accept_timeout", 66'(acc), 66'(1));
    endtask

    task automatic drainA();
        logic acc;
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 50) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, acc);
            n++;
        end
        checkOutput("drain_timeout", 66'(sbQ.size()), 66'(0));
    endtask

    task automatic directA(input logic [63:0] d, input logic ii, input logic [63:0] exp);
        sendA(d, ii, 1'b1);
        drainA();
        checkOutput("dir_data", 66'(lastOut), 66'(exp));
        checkOutput("dir_inv", 66'(lastOutInv), 66'(ii));
        checkOutput("dir_latency", 66'(lastLat), 66'(2));
    endtask

    // Sends one block into both 16-bit pipes at the same time. The task then
    // measures how many cycles pass before each pipe presents it.
    task automatic lat16(input logic [15:0] d, input logic ii, input logic [15:0] exp);
        int latB;
        int latC;
        logic [15:0] dB;
        logic [15:0] dC;
        logic iB;
        logic iC;
        latB = -1; latC = -1; dB = '0; dC = '0; iB = 1'b0; iC = 1'b0;
        b_in.valid = 1'b1; b_in.data = d; b_in.inv = ii; b_out.ready = 1'b1;
        c_in.valid = 1'b1; c_in.data = d; c_in.inv = ii; c_out.ready = 1'b1;
        @(negedge clk);
        checkOutput("w16_in_ready", 66'({b_in.ready, c_in.ready}), 66'(2'b11));
        @(posedge clk);
        #1;
        b_in.valid = 1'b0;
        c_in.valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (latB < 0 && b_out.valid) begin latB = n; dB = b_out.data; iB = b_out.inv; end
            if (latC < 0 && c_out.valid) begin latC = n; dC = c_out.data; iC = c_out.inv; end
            @(posedge clk);
            #1;
        end
        checkOutput("w16_s1_latency", 66'(latB), 66'(1));
        checkOutput("w16_s4_latency", 66'(latC), 66'(4));
        checkOutput("w16_s1_data", 66'(dB), 66'(exp));
        checkOutput("w16_s4_data", 66'(dC), 66'(exp));
        checkOutput("w16_s1_inv", 66'(iB), 66'(ii));
        checkOutput("w16_s4_inv", 66'(iC), 66'(ii));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        int accN;
        int k;
        int n;
        logic [63:0] blk [6];
        logic [15:0] r16;
        logic ri;

        a_in.valid = 1'b0; a_in.data = '0; a_in.inv = 1'b0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_in.inv = 1'b0; b_out.ready = 1'b0;
        c_in.valid = 1'b0; c_in.data = '0; c_in.inv = 1'b0; c_out.ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        checkOutput("reset_out_valid", 66'(a_out.valid), 66'(0));
        checkOutput("reset_out_data", 66'(a_out.data), 66'(0));
        checkOutput("reset_out_inv", 66'(a_out.inv), 66'(0));
        checkOutput("reset_w16_valid", 66'({b_out.valid, c_out.valid}), 66'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 66'({a_in.ready, b_in.ready, c_in.ready}), 66'(3'b111));

        // Single blocks on the 64-bit pipe, both directions
        directA(64'h0000_0000_0000_0002, 1'b0, 64'h0000_0000_0001_0000);
        directA(64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0002);
        directA(64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000);
        directA(64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000);
        directA(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        directA(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        directA(64'h0123_4567_89AB_CDEF, 1'b0, refPerm(64'h0123_4567_89AB_CDEF, 64, 1'b0));

        // 16-bit pipes at one and four stages
        lat16(16'h0002, 1'b0, 16'h0010);
        lat16(16'h0010, 1'b1, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            r16 = 16'($urandom);
            ri  = 1'($urandom_range(0, 1));
            lat16(r16, ri, refPerm(64'(r16), 16, ri)[15:0]);
        end

        // Round trip: 1000 random blocks forward, then the results inverse
        for (int i = 0; i < 1000; i++) orig[i] = {$urandom, $urandom};
        capQ.delete();
        emitCount = 0;
        accN = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, orig[i], 1'b0, 1'b1, acc);
            if (acc) accN++;
        end
        drainA();
        checkOutput("rt_fwd_accepts", 66'(accN), 66'(1000));
        checkOutput("rt_fwd_emits", 66'(emitCount), 66'(1000));
        checkOutput("rt_fwd_rate", 66'(lastEmitCyc - firstEmitCyc), 66'(999));
        for (int i = 0; i < 1000; i++) fwdRes[i] = (i < capQ.size()) ? capQ[i] : 64'h0;
        capQ.delete();
        emitCount = 0;
        accN = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, fwdRes[i], 1'b1, 1'b1, acc);
            if (acc) accN++;
        end
        drainA();
        checkOutput("rt_inv_accepts", 66'(accN), 66'(1000));
        checkOutput("rt_inv_rate", 66'(lastEmitCyc - firstEmitCyc), 66'(999));
        checkOutput("rt_inv_count", 66'(capQ.size()), 66'(1000));
        for (int i = 0; i < 1000 && i < capQ.size(); i++)
            checkOutput("rt_return", 66'(capQ[i]), 66'(orig[i]));

        // Full-pipe stall: six offered blocks, sink held off for six cycles
        for (int i = 0; i < 6; i++) blk[i] = {$urandom, $urandom};
        capQ.delete();
        emitCount = 0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, blk[k], 1'(k % 2), 1'b0, acc);
            if (acc) k++;
        end
        checkOutput("stall_accepted", 66'(k), 66'(2));
        checkOutput("stall_in_ready", 66'(a_in.ready), 66'(0));
        n = 0;
        while (k < 6 && n < 40) begin
            applyStimulus(1'b1, blk[k], 1'(k % 2), 1'b1, acc);
            if (acc) k++;
            n++;
        end
        drainA();
        checkOutput("stall_emitted", 66'(emitCount), 66'(6));
        for (int i = 0; i < 6 && i < capQ.size(); i++)
            checkOutput("stall_order", 66'(capQ[i]), 66'(refPerm(blk[i], 64, 1'(i % 2))));

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc);
        drainA();

        // Reset with two blocks in flight
        sendA(64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
        sendA(64'h1111_2222_3333_4444, 1'b1, 1'b0);
        checkOutput("pre_reset_valid", 66'(a_out.valid), 66'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 66'(a_out.valid), 66'(0));
        checkOutput("async_reset_data", 66'(a_out.data), 66'(0));
        checkOutput("async_reset_inv", 66'(a_out.inv), 66'(0));
        sbQ.delete();
        stallPrev = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", 66'(a_in.ready), 66'(1));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, acc);
            checkOutput("post_reset_no_stale", 66'(a_out.valid), 66'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
